// File: rtl/control_trace_decoder_if.sv
// Observed control-unit word plus the decoder's retirement/error trace outputs.
interface control_trace_decoder_if;
  localparam int unsigned FUNCT_W = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned CLASS_W = 4;
  localparam int unsigned COUNT_W = 16;
  localparam int unsigned CODE_W  = 3;
  localparam int unsigned PHASE_W = 3;

  logic               PCWrite;
  logic               PCWriteCond;
  logic               LoadIR;
  logic               LoadRegA;
  logic               LoadRegB;
  logic               LoadALUOut;
  logic               WriteReg;
  logic               LoadMDR;
  logic               DMemWrite;
  logic               ALUSrcA;
  logic               BranchOp;
  logic [FUNCT_W-1:0] ALUFunct;
  logic [SEL_W-1:0]   ALUSrcB;
  logic [SEL_W-1:0]   MemToReg;

  logic               retired_valid;
  logic [CLASS_W-1:0] retired_class;
  logic [COUNT_W-1:0] retired_count;
  logic               error;
  logic [CODE_W-1:0]  error_code;
  logic [PHASE_W-1:0] phase;

  modport master (
    output PCWrite, PCWriteCond, LoadIR, LoadRegA, LoadRegB, LoadALUOut,
           WriteReg, LoadMDR, DMemWrite, ALUSrcA, BranchOp,
           ALUFunct, ALUSrcB, MemToReg,
    input  retired_valid, retired_class, retired_count, error, error_code, phase
  );

  modport slave (
    input  PCWrite, PCWriteCond, LoadIR, LoadRegA, LoadRegB, LoadALUOut,
           WriteReg, LoadMDR, DMemWrite, ALUSrcA, BranchOp,
           ALUFunct, ALUSrcB, MemToReg,
    output retired_valid, retired_class, retired_count, error, error_code, phase
  );
endinterface

// File: rtl/control_trace_decoder.sv
// Watches multi-cycle control-unit words, reconstructs instruction boundaries,
// and reports retirements, instruction counts and the first sequencing error.
module control_trace_decoder (
  input logic                    clk,
  input logic                    Reset,
  control_trace_decoder_if.slave bus
);
  localparam int unsigned CLASS_W = 4;
  localparam int unsigned COUNT_W = 16;
  localparam int unsigned CODE_W  = 3;
  localparam int unsigned STALL_W = 4;

  localparam logic [CLASS_W-1:0] CLS_NONE = 4'd0;
  localparam logic [CLASS_W-1:0] CLS_ADD  = 4'd1;
  localparam logic [CLASS_W-1:0] CLS_SUB  = 4'd2;
  localparam logic [CLASS_W-1:0] CLS_ADDI = 4'd3;
  localparam logic [CLASS_W-1:0] CLS_LD   = 4'd4;
  localparam logic [CLASS_W-1:0] CLS_SD   = 4'd5;
  localparam logic [CLASS_W-1:0] CLS_LUI  = 4'd6;
  localparam logic [CLASS_W-1:0] CLS_BEQ  = 4'd7;
  localparam logic [CLASS_W-1:0] CLS_BNE  = 4'd8;

  localparam logic [CODE_W-1:0] ERR_NONE    = 3'd0;
  localparam logic [CODE_W-1:0] ERR_SEQ     = 3'd1;
  localparam logic [CODE_W-1:0] ERR_ILLEGAL = 3'd2;
  localparam logic [CODE_W-1:0] ERR_TIMEOUT = 3'd3;

  localparam logic [2:0]         FUNCT_ADD   = 3'b001;
  localparam logic [2:0]         FUNCT_SUB   = 3'b010;
  localparam logic [STALL_W-1:0] STALL_LIMIT = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCHED = 3'd1,
    S_DECODED = 3'd2,
    S_EXEC_R  = 3'd3,
    S_OFFSET  = 3'd4,
    S_LDMEM   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    W_FETCH, W_DEC, W_RALU, W_OFF, W_ST, W_MDR,
    W_WBA, W_WBM, W_WBU, W_BR, W_NULL, W_OTHER
  } word_t;

  state_t             state;
  state_t             state_nxt;
  word_t              word;
  logic [STALL_W-1:0] stall;
  logic               is_sub;
  logic [CODE_W-1:0]  err_nxt;
  logic [CLASS_W-1:0] retire_nxt;
  logic               any_en;

  logic               valid_q;
  logic [CLASS_W-1:0] class_q;
  logic [COUNT_W-1:0] count_q;
  logic               error_q;
  logic [CODE_W-1:0]  code_q;

  // Classify the observed word; earlier classes win on overlap.
  always_comb begin
    any_en = bus.PCWrite | bus.PCWriteCond | bus.LoadIR | bus.LoadRegA | bus.LoadRegB |
             bus.LoadALUOut | bus.WriteReg | bus.LoadMDR | bus.DMemWrite |
             bus.ALUSrcA | bus.BranchOp;
    word = W_OTHER;
    if (bus.LoadIR && bus.PCWrite && bus.ALUSrcB == 2'b01)
      word = W_FETCH;
    else if (bus.LoadRegA && bus.LoadRegB && bus.LoadALUOut && bus.ALUSrcB == 2'b11)
      word = W_DEC;
    else if (bus.LoadALUOut && bus.ALUSrcA && bus.ALUSrcB == 2'b00)
      word = W_RALU;
    else if (bus.LoadALUOut && bus.ALUSrcA && bus.ALUSrcB == 2'b10)
      word = W_OFF;
    else if (bus.DMemWrite)
      word = W_ST;
    else if (bus.LoadMDR)
      word = W_MDR;
    else if (bus.WriteReg && bus.MemToReg == 2'b00)
      word = W_WBA;
    else if (bus.WriteReg && bus.MemToReg == 2'b01)
      word = W_WBM;
    else if (bus.WriteReg && bus.MemToReg == 2'b10)
      word = W_WBU;
    else if (bus.PCWriteCond)
      word = W_BR;
    else if (!any_en)
      word = W_NULL;
  end

  // Transition table: next phase, error to raise, or class to retire.
  always_comb begin
    state_nxt  = state;
    err_nxt    = ERR_NONE;
    retire_nxt = CLS_NONE;
    if (state != S_IDLE && word == W_NULL) begin
      if (stall == STALL_LIMIT) err_nxt = ERR_TIMEOUT;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (word == W_FETCH) state_nxt = S_FETCHED;
        end
        S_FETCHED: begin
          if (word == W_DEC) state_nxt = S_DECODED;
          else               err_nxt   = ERR_SEQ;
        end
        S_DECODED: begin
          unique case (word)
            W_RALU: begin
              if (bus.ALUFunct == FUNCT_ADD || bus.ALUFunct == FUNCT_SUB) state_nxt = S_EXEC_R;
              else                                                         err_nxt   = ERR_SEQ;
            end
            W_OFF:   state_nxt  = S_OFFSET;
            W_WBU:   retire_nxt = CLS_LUI;
            W_BR:    retire_nxt = bus.BranchOp ? CLS_BNE : CLS_BEQ;
            W_FETCH: err_nxt    = ERR_ILLEGAL;
            default: err_nxt    = ERR_SEQ;
          endcase
        end
        S_EXEC_R: begin
          if (word == W_WBA) retire_nxt = is_sub ? CLS_SUB : CLS_ADD;
          else               err_nxt    = ERR_SEQ;
        end
        S_OFFSET: begin
          unique case (word)
            W_ST:    retire_nxt = CLS_SD;
            W_MDR:   state_nxt  = S_LDMEM;
            W_WBA:   retire_nxt = CLS_ADDI;
            default: err_nxt    = ERR_SEQ;
          endcase
        end
        S_LDMEM: begin
          if (word == W_WBM) retire_nxt = CLS_LD;
          else               err_nxt    = ERR_SEQ;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      stall   <= '0;
      is_sub  <= 1'b0;
      valid_q <= 1'b0;
      class_q <= CLS_NONE;
      count_q <= '0;
      error_q <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      valid_q <= 1'b0;
      if (state == S_DECODED && word == W_RALU) is_sub <= (bus.ALUFunct == FUNCT_SUB);
      if (err_nxt != ERR_NONE) begin
        state   <= S_IDLE;
        stall   <= '0;
        error_q <= 1'b1;
        if (!error_q) code_q <= err_nxt;
      end else if (retire_nxt != CLS_NONE) begin
        state   <= S_IDLE;
        stall   <= '0;
        valid_q <= 1'b1;
        class_q <= retire_nxt;
        count_q <= count_q + COUNT_W'(1);
      end else begin
        state <= state_nxt;
        // NULL words in an open instruction accumulate; anything else restarts the count.
        if (state_nxt != S_IDLE && word == W_NULL) stall <= stall + STALL_W'(1);
        else                                        stall <= '0;
      end
    end
  end

  assign bus.retired_valid = valid_q;
  assign bus.retired_class = class_q;
  assign bus.retired_count = count_q;
  assign bus.error         = error_q;
  assign bus.error_code    = code_q;
  assign bus.phase         = 3'(state);

endmodule

// File: tb/tb_control_trace_decoder.sv
// Bench for control_trace_decoder: directed scenarios plus randomized words,
// checked every cycle against a sequence-matching reference model.
module tb_control_trace_decoder;
  localparam int T_NULL = 0, T_FETCH = 1, T_DEC = 2, T_RADD = 3, T_RSUB = 4, T_RBAD = 5,
                 T_OFF = 6, T_ST = 7, T_MDR = 8, T_WBA = 9, T_WBM = 10, T_WBU = 11,
                 T_BR0 = 12, T_BR1 = 13, T_OTHER = 14;

  // Legal instruction shapes as token strings, with their retired class.
  int pat [8][5] = '{'{1, 2, 3, 9, 0}, '{1, 2, 4, 9, 0}, '{1, 2, 6, 9, 0}, '{1, 2, 6, 8, 10},
                     '{1, 2, 6, 7, 0}, '{1, 2, 11, 0, 0}, '{1, 2, 12, 0, 0}, '{1, 2, 13, 0, 0}};
  int plen [8] = '{4, 4, 4, 5, 4, 3, 3, 3};
  int pcls [8] = '{1, 2, 3, 4, 5, 6, 7, 8};

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  control_trace_decoder_if bus();
  control_trace_decoder dut (.clk(clk), .Reset(Reset), .bus(bus.slave));

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  int seq[$];
  int m_nulls, m_class, m_count, m_err, m_code;
  bit m_valid;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int classify();
    if (bus.LoadIR && bus.PCWrite && bus.ALUSrcB == 2'b01) return T_FETCH;
    if (bus.LoadRegA && bus.LoadRegB && bus.LoadALUOut && bus.ALUSrcB == 2'b11) return T_DEC;
    if (bus.LoadALUOut && bus.ALUSrcA && bus.ALUSrcB == 2'b00)
      return (bus.ALUFunct == 3'd1) ? T_RADD : (bus.ALUFunct == 3'd2) ? T_RSUB : T_RBAD;
    if (bus.LoadALUOut && bus.ALUSrcA && bus.ALUSrcB == 2'b10) return T_OFF;
    if (bus.DMemWrite) return T_ST;
    if (bus.LoadMDR) return T_MDR;
    if (bus.WriteReg && bus.MemToReg == 2'b00) return T_WBA;
    if (bus.WriteReg && bus.MemToReg == 2'b01) return T_WBM;
    if (bus.WriteReg && bus.MemToReg == 2'b10) return T_WBU;
    if (bus.PCWriteCond) return bus.BranchOp ? T_BR1 : T_BR0;
    if ({bus.PCWrite, bus.LoadIR, bus.LoadRegA, bus.LoadRegB, bus.LoadALUOut, bus.WriteReg,
         bus.LoadMDR, bus.DMemWrite, bus.ALUSrcA, bus.BranchOp} == '0) return T_NULL;
    return T_OTHER;
  endfunction

  function automatic int full_class();
    for (int p = 0; p < 8; p++) begin
      if (plen[p] == seq.size()) begin
        bit ok = 1'b1;
        for (int i = 0; i < plen[p]; i++) if (pat[p][i] != seq[i]) ok = 1'b0;
        if (ok) return pcls[p];
      end
    end
    return 0;
  endfunction

  function automatic bit is_prefix();
    for (int p = 0; p < 8; p++) begin
      if (plen[p] > seq.size()) begin
        bit ok = 1'b1;
        for (int i = 0; i < seq.size(); i++) if (pat[p][i] != seq[i]) ok = 1'b0;
        if (ok) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic int exp_phase();
    case (seq.size())
      0: return 0;
      1: return 1;
      2: return 2;
      3: return (seq[2] == T_RADD || seq[2] == T_RSUB) ? 3 : 4;
      default: return 5;
    endcase
  endfunction

  task automatic raise(int code);
    if (m_err == 0) m_code = code;
    m_err = 1;
    seq.delete();
    m_nulls = 0;
  endtask

  task automatic model_step();
    int tok;
    int c;
    tok = classify();
    m_valid = 1'b0;
    if (Reset) begin
      seq.delete();
      m_nulls = 0; m_class = 0; m_count = 0; m_err = 0; m_code = 0;
      return;
    end
    if (seq.size() == 0) begin
      if (tok == T_FETCH) seq.push_back(tok);
      return;
    end
    if (tok == T_NULL) begin
      m_nulls++;
      if (m_nulls == 8) raise(3);
      return;
    end
    m_nulls = 0;
    seq.push_back(tok);
    c = full_class();
    if (c != 0) begin
      m_valid = 1'b1;
      m_class = c;
      m_count = (m_count + 1) % 65536;
      seq.delete();
    end else if (!is_prefix()) begin
      raise((seq.size() == 3 && seq[2] == T_FETCH) ? 2 : 1);
    end
  endtask

  // Model advances on each sampled edge; outputs compared just after it.
  always @(posedge clk) begin
    model_step();
    #1;
    if (cmp_en) begin
      chk("retired_valid", 32'(bus.retired_valid), 32'(m_valid));
      chk("retired_class", 32'(bus.retired_class), 32'(m_class));
      chk("retired_count", 32'(bus.retired_count), 32'(m_count));
      chk("error", 32'(bus.error), 32'(m_err));
      chk("error_code", 32'(bus.error_code), 32'(m_code));
      chk("phase", 32'(bus.phase), 32'(exp_phase()));
    end
  end

  task automatic put_tok(int tok);
    int f;
    {bus.PCWrite, bus.PCWriteCond, bus.LoadIR, bus.LoadRegA, bus.LoadRegB, bus.LoadALUOut,
     bus.WriteReg, bus.LoadMDR, bus.DMemWrite, bus.ALUSrcA, bus.BranchOp} = 11'd0;
    bus.ALUFunct = 3'($urandom_range(0, 7));
    bus.ALUSrcB  = 2'($urandom_range(0, 3));
    bus.MemToReg = 2'($urandom_range(0, 3));
    case (tok)
      T_FETCH: begin bus.LoadIR = 1'b1; bus.PCWrite = 1'b1; bus.ALUSrcB = 2'b01; end
      T_DEC: begin
        bus.LoadRegA = 1'b1; bus.LoadRegB = 1'b1; bus.LoadALUOut = 1'b1; bus.ALUSrcB = 2'b11;
      end
      T_RADD, T_RSUB, T_RBAD: begin
        bus.LoadALUOut = 1'b1; bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b00;
        f = $urandom_range(2, 7);
        if (f == 2) f = 0;
        bus.ALUFunct = (tok == T_RADD) ? 3'd1 : (tok == T_RSUB) ? 3'd2 : 3'(f);
      end
      T_OFF: begin bus.LoadALUOut = 1'b1; bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; end
      T_ST:  bus.DMemWrite = 1'b1;
      T_MDR: bus.LoadMDR = 1'b1;
      T_WBA: begin bus.WriteReg = 1'b1; bus.MemToReg = 2'b00; end
      T_WBM: begin bus.WriteReg = 1'b1; bus.MemToReg = 2'b01; end
      T_WBU: begin bus.WriteReg = 1'b1; bus.MemToReg = 2'b10; end
      T_BR0: begin bus.PCWriteCond = 1'b1; bus.BranchOp = 1'b0; end
      T_BR1: begin bus.PCWriteCond = 1'b1; bus.BranchOp = 1'b1; end
      T_OTHER: begin bus.WriteReg = 1'b1; bus.MemToReg = 2'b11; end
      default: ;
    endcase
    @(negedge clk);
  endtask

  task automatic put_raw();
    {bus.PCWrite, bus.PCWriteCond, bus.LoadIR, bus.LoadRegA, bus.LoadRegB, bus.LoadALUOut,
     bus.WriteReg, bus.LoadMDR, bus.DMemWrite, bus.ALUSrcA, bus.BranchOp} = 11'($urandom);
    bus.ALUFunct = 3'($urandom);
    bus.ALUSrcB  = 2'($urandom);
    bus.MemToReg = 2'($urandom);
    // Keep words with only select bits set out of the stream.
    if ({bus.PCWrite, bus.PCWriteCond, bus.LoadIR, bus.LoadRegA, bus.LoadRegB, bus.LoadALUOut,
         bus.WriteReg, bus.LoadMDR, bus.DMemWrite} == 9'd0) begin
      bus.ALUSrcA  = 1'b0;
      bus.BranchOp = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    put_tok(T_FETCH);
    Reset = 1'b0;
  endtask

  task automatic run_seq(int p);
    for (int i = 0; i < plen[p]; i++) put_tok(pat[p][i]);
  endtask

  initial begin
    int r;
    int p;
    Reset = 1'b1;
    cmp_en = 1'b1;
    put_tok(T_NULL);
    chk("reset_phase", 32'(bus.phase), 32'd0);
    chk("reset_count", 32'(bus.retired_count), 32'd0);
    chk("reset_error", 32'(bus.error), 32'd0);
    Reset = 1'b0;

    // SUB retires one cycle after its write-back word.
    put_tok(T_FETCH); put_tok(T_DEC); put_tok(T_RSUB);
    chk("sub_no_early_pulse", 32'(bus.retired_valid), 32'd0);
    put_tok(T_WBA);
    chk("sub_valid", 32'(bus.retired_valid), 32'd1);
    chk("sub_class", 32'(bus.retired_class), 32'd2);
    chk("sub_count", 32'(bus.retired_count), 32'd1);
    chk("sub_phase", 32'(bus.phase), 32'd0);
    put_tok(T_NULL);
    chk("sub_pulse_one_cycle", 32'(bus.retired_valid), 32'd0);

    // LD then SD.
    do_reset();
    run_seq(3);
    chk("ld_class", 32'(bus.retired_class), 32'd4);
    run_seq(4);
    chk("sd_class", 32'(bus.retired_class), 32'd5);
    chk("ldsd_count", 32'(bus.retired_count), 32'd2);
    chk("ldsd_error", 32'(bus.error), 32'd0);

    // Illegal FETCH after DEC, then a BNE still retires and the code sticks.
    do_reset();
    put_tok(T_FETCH); put_tok(T_DEC); put_tok(T_FETCH);
    chk("ill_error", 32'(bus.error), 32'd1);
    chk("ill_code", 32'(bus.error_code), 32'd2);
    chk("ill_phase", 32'(bus.phase), 32'd0);
    put_tok(T_FETCH); put_tok(T_DEC); put_tok(T_ST);
    chk("ill_code_kept", 32'(bus.error_code), 32'd2);
    run_seq(7);
    chk("bne_class", 32'(bus.retired_class), 32'd8);
    chk("bne_count", 32'(bus.retired_count), 32'd1);

    // Timeout boundary: 7 NULLs tolerated, the 8th trips.
    do_reset();
    put_tok(T_FETCH); put_tok(T_DEC);
    repeat (7) put_tok(T_NULL);
    chk("to7_error", 32'(bus.error), 32'd0);
    chk("to7_phase", 32'(bus.phase), 32'd2);
    put_tok(T_NULL);
    chk("to8_error", 32'(bus.error), 32'd1);
    chk("to8_code", 32'(bus.error_code), 32'd3);
    do_reset();
    put_tok(T_FETCH); put_tok(T_DEC);
    repeat (7) put_tok(T_NULL);
    put_tok(T_WBU);
    chk("to7_lui_class", 32'(bus.retired_class), 32'd6);
    chk("to7_lui_error", 32'(bus.error), 32'd0);

    // Reset in OFFSET abandons the instruction and clears count and error.
    put_tok(T_FETCH); put_tok(T_DEC); put_tok(T_DEC);
    put_tok(T_FETCH); put_tok(T_DEC); put_tok(T_OFF);
    chk("off_phase", 32'(bus.phase), 32'd4);
    Reset = 1'b1;
    put_tok(T_MDR);
    Reset = 1'b0;
    chk("rst_off_phase", 32'(bus.phase), 32'd0);
    chk("rst_off_count", 32'(bus.retired_count), 32'd0);
    chk("rst_off_valid", 32'(bus.retired_valid), 32'd0);
    chk("rst_off_error", 32'(bus.error), 32'd0);
    put_tok(T_WBM);
    chk("rst_off_no_ld", 32'(bus.retired_valid), 32'd0);

    // Count wrap.
    do_reset();
    repeat (65535) run_seq(5);
    chk("wrap_ffff", 32'(bus.retired_count), 32'hFFFF);
    run_seq(5);
    chk("wrap_zero", 32'(bus.retired_count), 32'h0000);
    chk("wrap_valid", 32'(bus.retired_valid), 32'd1);

    // Randomized mix of legal shapes, stray tokens, raw words, stalls and resets.
    for (int it = 0; it < 1500; it++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        Reset = 1'b1;
        put_tok($urandom_range(0, 14));
        Reset = 1'b0;
      end else if (r < 14) begin
        put_raw();
      end else if (r < 26) begin
        put_tok($urandom_range(0, 14));
      end else begin
        p = $urandom_range(0, 7);
        for (int i = 0; i < plen[p]; i++) begin
          if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 9)) put_tok(T_NULL);
          put_tok(pat[p][i]);
        end
      end
    end

    put_tok(T_NULL);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/control_trace_decoder.md
CONTROL_TRACE_DECODER -- requirements
Module: control_trace_decoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; it SHALL NOT use any other clock or asynchronous reset.
REQ-002 clk  input  1  rising-edge clock, shared with the control unit and datapath.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 PCWrite, PCWriteCond, LoadIR, LoadRegA, LoadRegB, LoadALUOut, WriteReg, LoadMDR, DMemWrite, ALUSrcA, BranchOp  input  1 each  observed control-unit outputs.
REQ-005 ALUFunct  input  3  observed ALU function; ALUSrcB  input  2; MemToReg  input  2.
REQ-006 retired_valid  output  1  one-cycle pulse: one instruction completed.
REQ-007 retired_class  output  4  class of the completed instruction, valid with retired_valid: 1 ADD, 2 SUB, 3 ADDI, 4 LD, 5 SD, 6 LUI, 7 BEQ, 8 BNE; otherwise holds its last value.
REQ-008 retired_count  output  16  count of retired instructions, modulo 2^16.
REQ-009 error  output  1  sticky error flag; error_code  output  3  code of the first error (1 SEQ, 2 ILLEGAL_OP, 3 TIMEOUT).
REQ-010 phase  output  3  current decoder state: 0 IDLE, 1 FETCHED, 2 DECODED, 3 EXEC_R, 4 OFFSET, 5 LDMEM.

Function
REQ-011 Word classes, sampled each rising edge:
- FETCH: LoadIR=1, PCWrite=1, ALUSrcB=01.
- DEC: LoadRegA=1, LoadRegB=1, LoadALUOut=1, ALUSrcB=11.
- RALU: LoadALUOut=1, ALUSrcA=1, ALUSrcB=00.
- OFF: LoadALUOut=1, ALUSrcA=1, ALUSrcB=10.
- ST: DMemWrite=1.
- MDR: LoadMDR=1.
- WBA: WriteReg=1, MemToReg=00. WBM: WriteReg=1, MemToReg=01. WBU: WriteReg=1, MemToReg=10.
- BR: PCWriteCond=1.
- NULL: all 1-bit enables 0.
REQ-012 Word classes SHALL be checked in the order listed in REQ-011; the first match wins, and DEC takes precedence over WB* in phase FETCHED.
REQ-013 IDLE: FETCH → FETCHED; NULL → stay in IDLE; any other word → stay in IDLE, no error.
REQ-014 FETCHED: DEC → DECODED; any other non-NULL word → SEQ error.
REQ-015 DECODED transitions:
- RALU → EXEC_R; capture ALUFunct, where 001 is ADD, 010 is SUB, and any other value is SEQ error.
- OFF → OFFSET.
- WBU → retire LUI.
- BR → retire BEQ if BranchOp=0, BNE if BranchOp=1.
- FETCH → ILLEGAL_OP error.
- Any other non-NULL word → SEQ error.
REQ-016 EXEC_R: WBA → retire the captured ADD/SUB; any other non-NULL word → SEQ error.
REQ-017 OFFSET transitions:
- ST → retire SD.
- MDR → LDMEM.
- WBA → retire ADDI.
- Any other non-NULL word → SEQ error.
REQ-018 LDMEM: WBM → retire LD; any other non-NULL word → SEQ error.
REQ-019 Retire SHALL mean all of the following at the next edge:
- phase → IDLE;
- retired_valid=1 for exactly one cycle;
- retired_class updated;
- retired_count incremented, wrapping 0xFFFF→0x0000.
Latency is one cycle from the completing word to retired_valid.
REQ-020 Stall counter (4 bits):
- In any phase other than IDLE, a NULL word increments it and the phase holds.
- On the 8th consecutive NULL word: TIMEOUT error.
- It SHALL clear on any non-NULL word and on entry to IDLE.
REQ-021 On any error:
- phase → IDLE at the next edge;
- error=1, and it stays set until Reset;
- error_code is written only if error was 0, so later errors SHALL NOT overwrite it;
- no retire occurs and retired_count is unchanged.
REQ-022 Decoding SHALL continue after an error; later instructions SHALL retire normally.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 While Reset=1, at each edge the block SHALL set: phase=IDLE, retired_valid=0, retired_class=0, retired_count=0, error=0, error_code=0, stall counter=0.
REQ-025 Reset SHALL override every concurrent word; asserting Reset mid-instruction SHALL abandon that instruction with no retire and no error.

Verification
REQ-026 Each of the following directed scenarios SHALL be covered:
- FETCH, DEC, RALU(ALUFunct=010), WBA → retired_valid pulse one cycle after WBA, class=2, count=1, phase=0.
- FETCH, DEC, OFF, MDR, WBM, then FETCH, DEC, OFF, ST → two pulses, classes 4 then 5, count=2, error=0.
- FETCH, DEC, FETCH → error=1, code=2, phase=0; then FETCH, DEC, BR(BranchOp=1) → class=8 retires and code stays 2.
- FETCH, DEC, then 8 NULL words → error=1, code=3 after the 8th NULL word; with only 7 NULL words then WBU → LUI retires and error=0.
- Preload count=0xFFFF via 65535 LUI sequences, then one more → count=0x0000.
- Reset asserted in OFFSET → next cycle phase=0, count=0, no pulse.
